// File: rtl/audio_pkt_pkg.sv
// Shared types and constants for the audio packet scheduler.
// AUDIO_PKT_CHKSUM_EN adds the TRAIL checksum state.
package audio_pkt_pkg;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam int HDR_LEN = 4;

`ifdef AUDIO_PKT_CHKSUM_EN
  localparam int TRAIL_LEN = 1;
  typedef enum logic [1:0] {
    IDLE, HDR, PAYLOAD, TRAIL
  } state_t;
`else
  localparam int TRAIL_LEN = 0;
  typedef enum logic [1:0] {
    IDLE, HDR, PAYLOAD
  } state_t;
`endif

  function automatic logic [15:0] pkt_len(
    input int spp
  );
    return 16'(HDR_LEN + 2 * spp + TRAIL_LEN);
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// First-word-fall-through sample FIFO with occupancy count.
// Writes into a full FIFO are discarded and flagged on drop.
module audio_sample_fifo #(
  parameter int DEPTH = 64,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [15:0]   wdata,
  input  logic          rd,
  output logic [15:0]   rdata,
  output logic [CW-1:0] count,
  output logic          drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PMAX = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          do_wr;
  logic          do_rd;

  // Fullness uses the count before any same-cycle pop.
  assign full  = (count == CMAX);
  assign do_wr = wr && !full;
  assign do_rd = rd && (count != '0);
  assign drop  = wr && full;
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_wr && !rst) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) begin
        wptr <= (wptr == PMAX) ? '0 : wptr + AW'(1);
      end
      if (do_rd) begin
        rptr <= (rptr == PMAX) ? '0 : rptr + AW'(1);
      end
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/audio_pkt_sched.sv
// Two-channel audio packetiser feeding a UDP byte stream.
// AUDIO_PKT_CHKSUM_EN appends an XOR checksum byte.
module audio_pkt_sched
  import audio_pkt_pkg::*;
#(
  parameter int SAMPLES_PER_PKT = 32,
  parameter int FIFO_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] ch0_data,
  input  logic        ch0_valid,
  input  logic [15:0] ch1_data,
  input  logic        ch1_valid,
  output logic        udp_send_data_valid,
  input  logic        udp_send_data_ready,
  output logic [7:0]  udp_send_data,
  output logic [15:0] udp_send_data_length,
  output logic        busy,
  output logic [15:0] drop_cnt0,
  output logic [15:0] drop_cnt1
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(SAMPLES_PER_PKT) + 1;
  localparam logic [CW-1:0] SPP_C =
    CW'(SAMPLES_PER_PKT);
  localparam logic [SW-1:0] LAST_S =
    SW'(SAMPLES_PER_PKT - 1);
  localparam logic [15:0] PKT_LEN =
    pkt_len(SAMPLES_PER_PKT);

  state_t        state;
  state_t        state_nx;
  logic          start;
  logic          done;
  logic          fire;
  logic          ch;
  logic          last;
  logic          pick;
  logic          elig0;
  logic          elig1;
  logic [1:0]    hidx;
  logic [SW-1:0] scnt;
  logic          lo;
  logic [15:0]   seq0;
  logic [15:0]   seq1;
  logic [15:0]   seq_cur;
  logic [15:0]   sample;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;
  logic [15:0]   rdata0;
  logic [15:0]   rdata1;
  logic          drop0;
  logic          drop1;
  logic          rd0;
  logic          rd1;
  logic          pop;
`ifdef AUDIO_PKT_CHKSUM_EN
  logic [7:0]    chk;
`endif

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .wr    (ch0_valid),
    .wdata (ch0_data),
    .rd    (rd0),
    .rdata (rdata0),
    .count (cnt0),
    .drop  (drop0)
  );

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .wr    (ch1_valid),
    .wdata (ch1_data),
    .rd    (rd1),
    .rdata (rdata1),
    .count (cnt1),
    .drop  (drop1)
  );

  assign elig0 = (cnt0 >= SPP_C);
  assign elig1 = (cnt1 >= SPP_C);
  // Both eligible: serve whichever was not served last.
  assign pick  = (elig0 && elig1) ? ~last : elig1;

  assign busy = (state != IDLE);
  assign udp_send_data_valid = busy;
  assign udp_send_data_length =
    busy ? PKT_LEN : 16'd0;
  assign fire = udp_send_data_valid &&
                udp_send_data_ready;

  assign pop = fire && (state == PAYLOAD) && lo;
  assign rd0 = pop && !ch;
  assign rd1 = pop && ch;

  assign seq_cur = ch ? seq1 : seq0;
  assign sample  = ch ? rdata1 : rdata0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && (elig0 || elig1)) begin
          state_nx = HDR;
          start    = 1'b1;
        end
      end
      HDR: begin
        if (fire && (hidx == 2'd3)) begin
          state_nx = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (pop && (scnt == LAST_S)) begin
`ifdef AUDIO_PKT_CHKSUM_EN
          state_nx = TRAIL;
`else
          state_nx = IDLE;
          done     = 1'b1;
`endif
        end
      end
`ifdef AUDIO_PKT_CHKSUM_EN
      TRAIL: begin
        if (fire) begin
          state_nx = IDLE;
          done     = 1'b1;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    udp_send_data = 8'd0;
    unique case (state)
      HDR: begin
        unique case (hidx)
          2'd0: udp_send_data = HDR_MAGIC;
          2'd1: udp_send_data = {7'b0, ch};
          2'd2: udp_send_data = seq_cur[15:8];
          2'd3: udp_send_data = seq_cur[7:0];
        endcase
      end
      PAYLOAD: begin
        udp_send_data =
          lo ? sample[7:0] : sample[15:8];
      end
`ifdef AUDIO_PKT_CHKSUM_EN
      TRAIL: udp_send_data = chk;
`endif
      default: udp_send_data = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch   <= 1'b0;
      last <= 1'b1;
      hidx <= '0;
      scnt <= '0;
      lo   <= 1'b0;
      seq0 <= '0;
      seq1 <= '0;
`ifdef AUDIO_PKT_CHKSUM_EN
      chk  <= '0;
`endif
    end else begin
      if (start) begin
        ch   <= pick;
        last <= pick;
        hidx <= '0;
        scnt <= '0;
        lo   <= 1'b0;
`ifdef AUDIO_PKT_CHKSUM_EN
        chk  <= '0;
`endif
      end
      if (fire) begin
`ifdef AUDIO_PKT_CHKSUM_EN
        chk <= chk ^ udp_send_data;
`endif
        if (state == HDR) begin
          hidx <= hidx + 2'd1;
        end
        if (state == PAYLOAD) begin
          lo <= ~lo;
          if (lo) begin
            scnt <= scnt + SW'(1);
          end
        end
      end
      if (done) begin
        if (ch) begin
          seq1 <= seq1 + 16'd1;
        end else begin
          seq0 <= seq0 + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt0 <= '0;
      drop_cnt1 <= '0;
    end else begin
      if (drop0 && (drop_cnt0 != 16'hFFFF)) begin
        drop_cnt0 <= drop_cnt0 + 16'd1;
      end
      if (drop1 && (drop_cnt1 != 16'hFFFF)) begin
        drop_cnt1 <= drop_cnt1 + 16'd1;
      end
    end
  end

endmodule
